// File: rtl/writer.sv
// Store-data formatter and memory write sequencer: byte-aligns a store into
// 64-bit lanes with byte enables and issues one or two req/ack write beats.
module writer #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    input  logic [2:0]        f3,
    output logic              write_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ready_d, req_d, done_d, err_d;
    logic [ADDR_W-1:0]   addr_d, hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0]   wdata_d, hi_wdata_q, hi_wdata_d;
    logic [BE_W-1:0]     be_d, hi_be_q, hi_be_d;

    logic [BE_W-1:0]     size_be;
    logic [DATA_W-1:0]   size_mask;
    logic [2*BE_W-1:0]   lane_mask;
    logic [2*DATA_W-1:0] lane_data;
    logic [ADDR_W-1:0]   base;

    // Size decode and lane alignment of the incoming store across two beats
    always_comb begin
        size_be   = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
        case (f3[1:0])
            2'b00: begin size_be = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
            2'b01: begin size_be = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
            2'b10: begin size_be = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin size_be = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        lane_mask = {8'h00, size_be} << addr[2:0];
        lane_data = {64'd0, store_data & size_mask} << {addr[2:0], 3'b000};
        base      = {addr[ADDR_W-1:3], 3'b000};
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        req_d      = mem_req;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        be_d       = mem_be;
        hi_addr_d  = hi_addr_q;
        hi_wdata_d = hi_wdata_q;
        hi_be_d    = hi_be_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (f3[2]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = BEAT0;
                        req_d      = 1'b1;
                        addr_d     = base;
                        be_d       = lane_mask[BE_W-1:0];
                        wdata_d    = lane_data[DATA_W-1:0];
                        hi_addr_d  = base + ADDR_W'(8);
                        hi_be_d    = lane_mask[2*BE_W-1:BE_W];
                        hi_wdata_d = lane_data[2*DATA_W-1:DATA_W];
                    end
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    if (hi_be_q != '0) begin
                        state_d = BEAT1;
                        addr_d  = hi_addr_q;
                        be_d    = hi_be_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ready_out  <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_out  <= ready_d;
            mem_req    <= req_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_be     <= be_d;
            done       <= done_d;
            err        <= err_d;
            hi_addr_q  <= hi_addr_d;
            hi_wdata_q <= hi_wdata_d;
            hi_be_q    <= hi_be_d;
        end
    end

    assign write_stall = (state_q != IDLE);

endmodule
